timeslice_arbiter: RTL

Time-slice round-robin arbiter that shares one resource between `N_REQ` requesters. Each grant lasts a programmable quantum of `i_quantum` cycles. The block embeds a modulo-k slot counter; its roll-over (`o_slot_end`) ends the current slot and advances the round-robin pointer. It sits in front of any shared datapath unit and drives that unit's select/enable from the one-hot grant.

---
 rtl/timeslice_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/timeslice_arbiter.sv
// timeslice_arbiter
// Time-slice round-robin arbiter. One requester at a time holds the
// shared resource for a slot of q = max(i_quantum, 1) cycles. A slot-end
// advances the round-robin pointer past the holder, so the holder is
// searched last when the next slot is picked.
// Optional feature: define TIMESLICE_ARB_EARLY_RELEASE_EN to end a slot
// in any cycle where the holder has dropped its request.
module timeslice_arbiter #(
    parameter int N_REQ = 4,
    parameter int W_Q   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [W_Q-1:0]           i_quantum,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_busy,
    output logic                     o_slot_end
);

    localparam int W_ID = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [W_ID-1:0] ptr_r, ptr_s;
    logic [W_ID-1:0] id_r, id_s;
    logic [W_Q-1:0]  cnt_r, cnt_s;
    logic [W_Q-1:0]  q_r, q_s;
    logic [N_REQ-1:0] grant_r;
    logic [W_Q-1:0]  q_lat_s;
    logic [W_ID-1:0] next_ptr_s;
    logic            slot_end_s;

    // First requester found searching base, base+1, ... (mod N_REQ).
    // Scanning offsets from the far end lets the nearest hit overwrite.
    function automatic logic [W_ID-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [W_ID-1:0]  base);
        logic [W_ID-1:0] pick;
        int              idx;
        pick = {W_ID{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx  = (int'(base) + i) % N_REQ;
            pick = req[idx] ? W_ID'(idx) : pick;
        end
        return pick;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [W_ID-1:0] id);
        logic [N_REQ-1:0] vec;
        vec     = {N_REQ{1'b0}};
        vec[id] = 1'b1;
        return vec;
    endfunction

    assign q_lat_s    = (i_quantum == {W_Q{1'b0}}) ? W_Q'(1) : i_quantum;
    assign next_ptr_s = (int'(id_r) == N_REQ - 1) ? {W_ID{1'b0}} : id_r + W_ID'(1);

    // Slot-end flag: counter at its last value, or (optionally) holder released.
    always_comb begin
        slot_end_s = 1'b0;
        if (state_r == ST_BUSY) begin
`ifdef TIMESLICE_ARB_EARLY_RELEASE_EN
            slot_end_s = (cnt_r == q_r - W_Q'(1)) || !i_req[id_r];
`else
            slot_end_s = (cnt_r == q_r - W_Q'(1));
`endif
        end else begin
            slot_end_s = 1'b0;
        end
    end

    // Next-state logic: slot start from IDLE, slot count, slot hand-over.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        id_s    = id_r;
        cnt_s   = cnt_r;
        q_s     = q_r;
        case (state_r)
            ST_IDLE: begin
                if (|i_req) begin
                    state_s = ST_BUSY;
                    id_s    = rr_pick(i_req, ptr_r);
                    cnt_s   = {W_Q{1'b0}};
                    q_s     = q_lat_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (slot_end_s) begin
                    ptr_s = next_ptr_s;
                    cnt_s = {W_Q{1'b0}};
                    if (|i_req) begin
                        state_s = ST_BUSY;
                        id_s    = rr_pick(i_req, next_ptr_s);
                        q_s     = q_lat_s;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + W_Q'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {W_Q{1'b0}};
            end
        endcase
    end

    // State, pointer, counter, latched quantum and registered grant vector.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= {W_ID{1'b0}};
            id_r    <= {W_ID{1'b0}};
            cnt_r   <= {W_Q{1'b0}};
            q_r     <= W_Q'(1);
            grant_r <= {N_REQ{1'b0}};
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            id_r    <= id_s;
            cnt_r   <= cnt_s;
            q_r     <= q_s;
            grant_r <= (state_s == ST_BUSY) ? onehot(id_s) : {N_REQ{1'b0}};
        end
    end

    assign o_grant    = grant_r;
    assign o_grant_id = id_r;
    assign o_busy     = (state_r == ST_BUSY);
    assign o_slot_end = slot_end_s;

endmodule
